// File: rtl/count_event_fifo_pkg.sv
// Shared definitions for the count event FIFO.
// Holds the count width, the event record width and the bit positions of
// each field inside a record {wrap, match, jump, value[3:0]}.
package count_event_fifo_pkg;

   localparam int CNT_W     = 4;
   localparam int REC_W     = 7;

   localparam int WRAP_BIT  = 6;
   localparam int MATCH_BIT = 5;
   localparam int JUMP_BIT  = 4;
   localparam int VALUE_LSB = 0;

   // Assemble one event record from its flags and the count value.
   function automatic logic [REC_W-1:0] pack_rec(input logic wrap,
                                                 input logic match,
                                                 input logic jump,
                                                 input logic [CNT_W-1:0] value);
      logic [REC_W-1:0] rec;
      rec                            = '0;
      rec[WRAP_BIT]                  = wrap;
      rec[MATCH_BIT]                 = match;
      rec[JUMP_BIT]                  = jump;
      rec[VALUE_LSB +: CNT_W]        = value;
      return rec;
   endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous first-word fall-through FIFO.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (control only)
//   wr_en     : push request; ignored when full unless a pop happens too
//   wr_data   : record to push
//   rd_en     : pop request; ignored when empty
//   rd_data   : head record, forced to zero while empty
//   level     : number of stored records, 0..DEPTH
//   full      : level == DEPTH
module evt_fifo
   import count_event_fifo_pkg::*;
#(
   parameter int DATA_W = REC_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     count;
   logic              empty;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == LW'(DEPTH));
   assign do_pop  = rd_en && !empty;
   // A full FIFO still accepts a push when the head leaves at the same edge.
   assign do_push = wr_en && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers wrap naturally since DEPTH is a power of two.
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; the output mux hides stale contents.
   always_ff @(posedge clk) begin
      if (do_push && !rst) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr];
   assign level   = count;

endmodule

// File: rtl/count_event_fifo.sv
// Watches an upstream 4-bit up counter and queues a record whenever it
// wraps (F->0), reaches the compare value, or jumps (load discontinuity).
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   c        : counter value sampled every cycle
//   cmp      : compare value for match detection
//   cmp_en   : enables match detection
//   ovf_clr  : clears the sticky overflow flag
//   ev_valid : a head record is available
//   ev_ready : consumer takes the head record
//   ev_data  : head record {wrap, match, jump, value[3:0]}
//   ev_level : number of stored records
//   ovf      : sticky flag, set when a record was dropped on a full FIFO
module count_event_fifo
   import count_event_fifo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CNT_W-1:0]         c,
   input  logic [CNT_W-1:0]         cmp,
   input  logic                     cmp_en,
   input  logic                     ovf_clr,
   output logic                     ev_valid,
   input  logic                     ev_ready,
   output logic [REC_W-1:0]         ev_data,
   output logic [$clog2(DEPTH):0]   ev_level,
   output logic                     ovf
);

   logic [CNT_W-1:0] prev_q;
   logic             prev_vld;
   logic             wrap;
   logic             match;
   logic             jump;
   logic             push;
   logic             pop;
   logic             full;
   logic             drop;
   logic [REC_W-1:0] rec;

   // Previous-count stage: prev_vld stays low for the first cycle after
   // reset so that cycle only primes prev_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= '0;
         prev_vld <= 1'b0;
      end else begin
         prev_q   <= c;
         prev_vld <= 1'b1;
      end
   end

   always_comb begin
      wrap  = 1'b0;
      match = 1'b0;
      jump  = 1'b0;
      if (prev_vld) begin
         wrap  = (prev_q == 4'hF) && (c == 4'h0);
         // A held count never re-fires the match.
         match = cmp_en && (c == cmp) && (c != prev_q);
         jump  = (c != prev_q) && (c != prev_q + CNT_W'(1));
      end
   end

   assign push = wrap || match || jump;
   assign rec  = pack_rec(wrap, match, jump, c);
   assign pop  = ev_valid && ev_ready;
   assign drop = push && full && !pop;

   evt_fifo #(
      .DATA_W (REC_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data (rec),
      .rd_en   (ev_ready),
      .rd_data (ev_data),
      .level   (ev_level),
      .full    (full)
   );

   assign ev_valid = (ev_level != '0);

   // A drop wins over a same-edge clear so no loss goes unreported.
   always_ff @(posedge clk) begin
      if (rst)          ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
   end

endmodule

// File: tb/tb_count_event_fifo.sv
module tb_count_event_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] c;
   logic [3:0] cmp;
   logic       cmp_en;
   logic       ovf_clr;
   logic       ev_valid;
   logic       ev_ready;
   logic [6:0] ev_data;
   logic [2:0] ev_level;
   logic       ovf;

   int n_cmp = 0;
   int n_bad = 0;

   count_event_fifo #(.DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .c        (c),
      .cmp      (cmp),
      .cmp_en   (cmp_en),
      .ovf_clr  (ovf_clr),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_data  (ev_data),
      .ev_level (ev_level),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [6:0] drain_a [4] = '{7'h15, 7'h1A, 7'h13, 7'h18};
   logic [6:0] drain_b [4] = '{7'h17, 7'h1C, 7'h11, 7'h16};
   logic [3:0] jmp_a   [5] = '{4'd5, 4'd10, 4'd3, 4'd8, 4'd13};
   logic [3:0] jmp_b   [4] = '{4'd2, 4'd7, 4'd12, 4'd1};
   logic [3:0] jmp_c   [3] = '{4'd9, 4'd14, 4'd3};

   initial begin
      rst = 1'b1; c = 4'd0; cmp = 4'd0; cmp_en = 1'b0; ovf_clr = 1'b0; ev_ready = 1'b1;
      step(); step();
      chk("rst_valid", 32'(ev_valid), 32'd0);
      chk("rst_level", 32'(ev_level), 32'd0);
      chk("rst_ovf",   32'(ovf),      32'd0);
      chk("rst_data",  32'(ev_data),  32'h00);

      // Free-running count: only the F->0 wrap produces a record.
      rst = 1'b0; c = 4'd0;
      step();
      chk("prime_valid", 32'(ev_valid), 32'd0);
      for (int i = 1; i <= 35; i++) begin
         c = 4'(i % 16);
         step();
         chk("free_valid", 32'(ev_valid), (c == 4'd0) ? 32'd1 : 32'd0);
         if (c == 4'd0) chk("free_wrap_data", 32'(ev_data), 32'h40);
      end

      // Match at 5, then held count does not re-fire.
      cmp = 4'd5; cmp_en = 1'b1;
      c = 4'd4; step(); chk("m4_valid", 32'(ev_valid), 32'd0);
      c = 4'd5; step(); chk("m5_valid", 32'(ev_valid), 32'd1);
      chk("m5_data", 32'(ev_data), 32'h25);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_valid", 32'(ev_valid), 32'd0);
      end

      // Load discontinuity, then combined wrap+match.
      cmp_en = 1'b0;
      c = 4'd6;  step(); chk("j6_valid", 32'(ev_valid), 32'd0);
      c = 4'd12; step(); chk("j12_data", 32'(ev_data), 32'h1C);
      c = 4'd15; step(); chk("j15_data", 32'(ev_data), 32'h1F);
      cmp = 4'd0; cmp_en = 1'b1;
      c = 4'd0;  step(); chk("wm_data", 32'(ev_data), 32'h60);
      chk("wm_level", 32'(ev_level), 32'd1);
      cmp_en = 1'b0;
      step(); chk("wm_drained", 32'(ev_level), 32'd0);

      // Overflow: five jumps with the consumer stalled.
      ev_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         c = jmp_a[i];
         step();
         chk("fill_level", 32'(ev_level), (i < 4) ? 32'(i + 1) : 32'd4);
      end
      chk("ovf_set", 32'(ovf), 32'd1);
      chk("ovf_head", 32'(ev_data), 32'h15);
      ev_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_a", 32'(ev_data), 32'(drain_a[i]));
         step();
      end
      chk("drain_a_empty", 32'(ev_valid), 32'd0);
      chk("ovf_sticky", 32'(ovf), 32'd1);
      ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
      chk("ovf_clr", 32'(ovf), 32'd0);

      // Full FIFO with simultaneous push and pop.
      ev_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         c = jmp_b[i];
         step();
      end
      chk("full_level", 32'(ev_level), 32'd4);
      ev_ready = 1'b1; c = 4'd6;
      step();
      chk("pp_level", 32'(ev_level), 32'd4);
      chk("pp_ovf",   32'(ovf),      32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("drain_b", 32'(ev_data), 32'(drain_b[i]));
         step();
      end
      chk("drain_b_empty", 32'(ev_level), 32'd0);

      // Reset with three records stored.
      ev_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         c = jmp_c[i];
         step();
      end
      chk("pre_rst_level", 32'(ev_level), 32'd3);
      rst = 1'b1; step(); rst = 1'b0;
      chk("mrst_valid", 32'(ev_valid), 32'd0);
      chk("mrst_level", 32'(ev_level), 32'd0);
      chk("mrst_ovf",   32'(ovf),      32'd0);
      chk("mrst_data",  32'(ev_data),  32'h00);
      c = 4'd8; step(); chk("post_rst_prime", 32'(ev_valid), 32'd0);
      c = 4'd9; step(); chk("post_rst_inc", 32'(ev_valid), 32'd0);
      c = 4'd15; step(); chk("post_rst_jump", 32'(ev_data), 32'h1F);

      // Drop and clear at the same edge: ovf ends set.
      for (int i = 0; i < 3; i++) begin
         c = jmp_b[i];
         step();
      end
      chk("full2_level", 32'(ev_level), 32'd4);
      ovf_clr = 1'b1; c = 4'd6;
      step();
      ovf_clr = 1'b0;
      chk("clr_drop_ovf", 32'(ovf), 32'd1);
      chk("clr_drop_level", 32'(ev_level), 32'd4);
      chk("clr_drop_head", 32'(ev_data), 32'h1F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
